// File: rtl/price_window_ctrl_pkg.sv
// Shared definitions for the price window controller.
// Holds default parameter values, the stock-id / buffer-address typedefs
// and the per-stock window-state enum.
package price_window_ctrl_pkg;

    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_BUFFER_SIZE  = 32;
    localparam int DEF_NUM_STOCKS   = 4;
    localparam int DEF_FP_WORD_SIZE = 64;

    localparam int DEF_SID_W  = $clog2(DEF_NUM_STOCKS);
    localparam int DEF_ADDR_W = $clog2(DEF_NUM_STOCKS * DEF_BUFFER_SIZE);

    typedef logic [DEF_SID_W-1:0]  stock_id_t;
    typedef logic [DEF_ADDR_W-1:0] buf_addr_t;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } win_state_e;

endpackage

// File: rtl/price_window_ctrl_window_ptr.sv
// window_ptr: per-stock write pointer and fill counter.
// Ports:
//   i_clk, i_reset_n : clock, synchronous active-low reset
//   i_accept         : a sample for this stock is written this cycle
//   i_flush          : clear this stock's window (wins over i_accept)
//   o_ptr            : current write slot inside the stock's window
//   o_full           : registered window-full flag
import price_window_ctrl_pkg::*;

module window_ptr #(
    parameter int BUFFER_SIZE = DEF_BUFFER_SIZE
) (
    input  logic                           i_clk,
    input  logic                           i_reset_n,
    input  logic                           i_accept,
    input  logic                           i_flush,
    output logic [$clog2(BUFFER_SIZE)-1:0] o_ptr,
    output logic                           o_full
);
    localparam int PTR_W = $clog2(BUFFER_SIZE);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full_q, full_d;
    win_state_e       state;

    // State is a pure function of the fill count.
    always_comb begin
        if (cnt_q == '0)
            state = EMPTY;
        else if (cnt_q == CNT_W'(BUFFER_SIZE))
            state = FULL;
        else
            state = FILLING;
    end

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (i_flush) begin
            ptr_d = '0;
            cnt_d = '0;
        end else if (i_accept) begin
            // Pointer keeps wrapping once full; the count saturates.
            ptr_d = ptr_q + PTR_W'(1);
            if (state != FULL)
                cnt_d = cnt_q + CNT_W'(1);
        end
        // Flag the fill from the next count so it lines up with o_valid.
        full_d = (cnt_d == CNT_W'(BUFFER_SIZE));
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            ptr_q  <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            cnt_q  <= cnt_d;
            full_q <= full_d;
        end
    end

    assign o_ptr  = ptr_q;
    assign o_full = full_q;

endmodule

// File: rtl/price_window_ctrl.sv
// price_window_ctrl: cleans top-of-book updates and issues them into a
// per-stock circular sample window for the volatility stage.
// Ports:
//   i_clk, i_reset_n          : clock, synchronous active-low reset
//   i_valid/i_stock_id/
//   i_best_ask/i_best_bid     : incoming update (0 price = empty side)
//   i_flush/i_flush_id        : clear one stock's window
//   o_valid/o_write_address/
//   o_stock_id/o_best_ask/
//   o_best_bid                : registered cleaned sample, 1-cycle latency
//   o_buffer_size_reciprocal  : constant 1/BUFFER_SIZE in Q32.32
//   o_window_full             : per-stock window-full flags
//   o_drop_count              : saturating count of rejected updates
import price_window_ctrl_pkg::*;

module price_window_ctrl #(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int BUFFER_SIZE  = DEF_BUFFER_SIZE,
    parameter int NUM_STOCKS   = DEF_NUM_STOCKS,
    parameter int FP_WORD_SIZE = DEF_FP_WORD_SIZE
) (
    input  logic                                       i_clk,
    input  logic                                       i_reset_n,
    input  logic                                       i_valid,
    input  logic [$clog2(NUM_STOCKS)-1:0]              i_stock_id,
    input  logic [DATA_WIDTH-1:0]                      i_best_ask,
    input  logic [DATA_WIDTH-1:0]                      i_best_bid,
    input  logic                                       i_flush,
    input  logic [$clog2(NUM_STOCKS)-1:0]              i_flush_id,
    output logic                                       o_valid,
    output logic [$clog2(NUM_STOCKS*BUFFER_SIZE)-1:0]  o_write_address,
    output logic [$clog2(NUM_STOCKS)-1:0]              o_stock_id,
    output logic [DATA_WIDTH-1:0]                      o_best_ask,
    output logic [DATA_WIDTH-1:0]                      o_best_bid,
    output logic [FP_WORD_SIZE-1:0]                    o_buffer_size_reciprocal,
    output logic [NUM_STOCKS-1:0]                      o_window_full,
    output logic [15:0]                                o_drop_count
);
    localparam int SID_W  = $clog2(NUM_STOCKS);
    localparam int PTR_W  = $clog2(BUFFER_SIZE);
    localparam int ADDR_W = SID_W + PTR_W;
    localparam logic [63:0] RECIP64 = 64'h1_0000_0000 / 64'(BUFFER_SIZE);

    logic [NUM_STOCKS-1:0][DATA_WIDTH-1:0] last_ask_q, last_ask_d;
    logic [NUM_STOCKS-1:0][DATA_WIDTH-1:0] last_bid_q, last_bid_d;
    logic [NUM_STOCKS-1:0][PTR_W-1:0]      ptr_all;
    logic [NUM_STOCKS-1:0]                 accept_vec, flush_vec;

    logic                  valid_q, valid_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [SID_W-1:0]      sid_q, sid_d;
    logic [DATA_WIDTH-1:0] ask_q, ask_d, bid_q, bid_d;
    logic [15:0]           drop_q, drop_d;

    logic [DATA_WIDTH-1:0] clean_ask, clean_bid;
    logic                  drop, accept;

    // Side cleaning: an empty side borrows the stock's last good value.
    always_comb begin
        clean_ask = (i_best_ask == '0) ? last_ask_q[i_stock_id] : i_best_ask;
        clean_bid = (i_best_bid == '0) ? last_bid_q[i_stock_id] : i_best_bid;
        drop = ((i_best_ask == '0) && (i_best_bid == '0)) ||
               (clean_ask == '0) || (clean_bid == '0) ||
               (clean_ask < clean_bid) ||
               (i_flush && (i_flush_id == i_stock_id));
        accept = i_valid && !drop;
    end

    always_comb begin
        last_ask_d = last_ask_q;
        last_bid_d = last_bid_q;
        valid_d    = accept;
        addr_d     = addr_q;
        sid_d      = sid_q;
        ask_d      = ask_q;
        bid_d      = bid_q;
        drop_d     = drop_q;
        if (accept) begin
            addr_d                 = {i_stock_id, ptr_all[i_stock_id]};
            sid_d                  = i_stock_id;
            ask_d                  = clean_ask;
            bid_d                  = clean_bid;
            last_ask_d[i_stock_id] = clean_ask;
            last_bid_d[i_stock_id] = clean_bid;
        end
        if (i_valid && drop && (drop_q != 16'hFFFF))
            drop_d = drop_q + 16'd1;
        if (i_flush) begin
            last_ask_d[i_flush_id] = '0;
            last_bid_d[i_flush_id] = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            last_ask_q <= '0;
            last_bid_q <= '0;
            valid_q    <= 1'b0;
            addr_q     <= '0;
            sid_q      <= '0;
            ask_q      <= '0;
            bid_q      <= '0;
            drop_q     <= '0;
        end else begin
            last_ask_q <= last_ask_d;
            last_bid_q <= last_bid_d;
            valid_q    <= valid_d;
            addr_q     <= addr_d;
            sid_q      <= sid_d;
            ask_q      <= ask_d;
            bid_q      <= bid_d;
            drop_q     <= drop_d;
        end
    end

    for (genvar s = 0; s < NUM_STOCKS; s++) begin : g_win
        assign accept_vec[s] = accept  && (i_stock_id == SID_W'(s));
        assign flush_vec[s]  = i_flush && (i_flush_id == SID_W'(s));

        window_ptr #(.BUFFER_SIZE(BUFFER_SIZE)) u_window_ptr (
            .i_clk     (i_clk),
            .i_reset_n (i_reset_n),
            .i_accept  (accept_vec[s]),
            .i_flush   (flush_vec[s]),
            .o_ptr     (ptr_all[s]),
            .o_full    (o_window_full[s])
        );
    end

    assign o_valid                  = valid_q;
    assign o_write_address          = addr_q;
    assign o_stock_id               = sid_q;
    assign o_best_ask               = ask_q;
    assign o_best_bid               = bid_q;
    assign o_drop_count             = drop_q;
    assign o_buffer_size_reciprocal = FP_WORD_SIZE'(RECIP64);

endmodule

// File: tb/tb_price_window_ctrl.sv
module tb_price_window_ctrl;
    localparam int NS = 4;
    localparam int BS = 32;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_valid = 1'b0;
    logic [1:0]  i_stock_id = '0;
    logic [31:0] i_best_ask = '0;
    logic [31:0] i_best_bid = '0;
    logic        i_flush = 1'b0;
    logic [1:0]  i_flush_id = '0;
    logic        o_valid;
    logic [6:0]  o_write_address;
    logic [1:0]  o_stock_id;
    logic [31:0] o_best_ask;
    logic [31:0] o_best_bid;
    logic [63:0] o_buffer_size_reciprocal;
    logic [3:0]  o_window_full;
    logic [15:0] o_drop_count;

    price_window_ctrl dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_valid(i_valid),
        .i_stock_id(i_stock_id), .i_best_ask(i_best_ask), .i_best_bid(i_best_bid),
        .i_flush(i_flush), .i_flush_id(i_flush_id),
        .o_valid(o_valid), .o_write_address(o_write_address), .o_stock_id(o_stock_id),
        .o_best_ask(o_best_ask), .o_best_bid(o_best_bid),
        .o_buffer_size_reciprocal(o_buffer_size_reciprocal),
        .o_window_full(o_window_full), .o_drop_count(o_drop_count)
    );

    always #5 i_clk = ~i_clk;

    int passed = 0;
    int total  = 0;

    // Reference model: per-stock history as plain integers.
    int m_la[NS], m_lb[NS], m_ptr[NS], m_cnt[NS];
    int m_drop;
    bit e_valid;
    int e_addr, e_sid, e_ask, e_bid;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin
            m_la[s] = 0; m_lb[s] = 0; m_ptr[s] = 0; m_cnt[s] = 0;
        end
        m_drop = 0;
        e_valid = 0; e_addr = 0; e_sid = 0; e_ask = 0; e_bid = 0;
    endtask

    task automatic check_outputs(input string tag);
        logic [3:0] e_full;
        for (int s = 0; s < NS; s++) e_full[s] = (m_cnt[s] == BS);
        chk({tag, ".valid"}, 64'(o_valid), 64'(e_valid));
        chk({tag, ".full"}, 64'(o_window_full), 64'(e_full));
        chk({tag, ".drops"}, 64'(o_drop_count), 64'(m_drop));
        if (e_valid) begin
            chk({tag, ".addr"}, 64'(o_write_address), 64'(e_addr));
            chk({tag, ".sid"}, 64'(o_stock_id), 64'(e_sid));
            chk({tag, ".ask"}, 64'(o_best_ask), 64'(e_ask));
            chk({tag, ".bid"}, 64'(o_best_bid), 64'(e_bid));
        end
    endtask

    // One clock of stimulus; the model predicts the registered outputs.
    task automatic step(input string tag, input bit v, input int id, input int ask,
                        input int bid, input bit fl = 0, input int fid = 0);
        int ca, cb;
        bit drop;
        i_valid = v; i_stock_id = 2'(id); i_best_ask = ask; i_best_bid = bid;
        i_flush = fl; i_flush_id = 2'(fid);
        ca = (ask == 0) ? m_la[id] : ask;
        cb = (bid == 0) ? m_lb[id] : bid;
        drop = (ask == 0 && bid == 0) || ca == 0 || cb == 0 || ca < cb || (fl && fid == id);
        e_valid = 0;
        if (v) begin
            if (drop) begin
                if (m_drop < 65535) m_drop++;
            end else begin
                e_valid = 1;
                e_addr = id * BS + m_ptr[id];
                e_sid = id; e_ask = ca; e_bid = cb;
                m_ptr[id] = (m_ptr[id] + 1) % BS;
                if (m_cnt[id] < BS) m_cnt[id]++;
                m_la[id] = ca; m_lb[id] = cb;
            end
        end
        if (fl) begin
            m_la[fid] = 0; m_lb[fid] = 0; m_ptr[fid] = 0; m_cnt[fid] = 0;
        end
        @(posedge i_clk); #1;
        check_outputs(tag);
    endtask

    task automatic do_reset(input string tag);
        i_reset_n = 1'b0;
        i_valid = 1'b1; i_stock_id = 2'd0; i_best_ask = 32'd77; i_best_bid = 32'd70;
        i_flush = 1'b0;
        @(posedge i_clk); #1;
        model_reset();
        chk({tag, ".valid"}, 64'(o_valid), 64'd0);
        chk({tag, ".addr"}, 64'(o_write_address), 64'd0);
        chk({tag, ".sid"}, 64'(o_stock_id), 64'd0);
        chk({tag, ".ask"}, 64'(o_best_ask), 64'd0);
        chk({tag, ".bid"}, 64'(o_best_bid), 64'd0);
        chk({tag, ".full"}, 64'(o_window_full), 64'd0);
        chk({tag, ".drops"}, 64'(o_drop_count), 64'd0);
        i_reset_n = 1'b1;
        i_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        @(posedge i_clk); #1;
        do_reset("rst0");
        chk("recip", o_buffer_size_reciprocal, 64'h0800_0000);

        step("s2_basic", 1, 2, 102, 100);
        chk("s2_addr64", 64'(o_write_address), 64'd64);
        step("idle", 0, 0, 0, 0);

        step("s0_a", 1, 0, 50, 48);
        step("s0_askfill", 1, 0, 0, 49);
        chk("s0_ask50", 64'(o_best_ask), 64'd50);
        step("s0_bothzero", 1, 0, 0, 0);
        chk("s0_drop1", 64'(o_drop_count), 64'd1);
        step("s0_crossed", 1, 0, 90, 95);
        chk("s0_drop2", 64'(o_drop_count), 64'd2);

        do_reset("rst1");
        step("s1_askonly", 1, 1, 100, 0);
        chk("s1_askonly_drop", 64'(o_drop_count), 64'd1);
        for (int i = 0; i < BS; i++) step("s1_fill", 1, 1, 100 + i, 100);
        chk("s1_full_rise", 64'(o_window_full[1]), 64'd1);
        step("s1_wrap", 1, 1, 200, 150);
        chk("s1_wrap_addr", 64'(o_write_address), 64'd32);

        step("s3_pre", 1, 3, 60, 55);
        step("s3_flush_same", 1, 3, 61, 55, 1, 3);
        step("s3_after", 1, 3, 62, 55);
        chk("s3_addr96", 64'(o_write_address), 64'd96);
        step("flush_other", 1, 2, 110, 105, 1, 1);
        chk("s1_flushed", 64'(o_window_full[1]), 64'd0);

        do_reset("rst2");
        for (int i = 0; i < 10; i++) step("s0_ten", 1, 0, 80 + i, 70);
        do_reset("rst_midfill");
        step("s0_restart", 1, 0, 80, 70);
        chk("s0_addr0", 64'(o_write_address), 64'd0);

        for (int n = 0; n < 600; n++) begin
            int a, b;
            a = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(90, 110));
            b = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(90, 110));
            step("rand", ($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)), a, b,
                 ($urandom_range(0, 15) == 0), int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
